// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the MIPS core.
// Owns the program counter. Issues word fetches over a req/ack handshake and
// hands each instruction, with its PC and PC+4, to decode over valid/ready.
// Redirects from execute can arrive while a memory request is outstanding.
// In that case the memory answer is dropped and the redirect target is fetched next.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to route misaligned redirect
// targets to EXC_VECTOR and report them on misalign_exc / misalign_epc.
// If the macro is not defined, the low two target bits are forced to zero.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_exc,
    output logic [31:0] misalign_epc
);

    // S_FETCH: request in flight. S_OUT: instruction waiting for decode.
    // S_DROP: request in flight whose answer must be thrown away.
    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_OUT   = 2'b01,
        S_DROP  = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pending_pc_r;
    logic [31:0] pending_pc_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic [31:0] instr_pc_r;
    logic [31:0] instr_pc_s;
    logic [31:0] instr_pcplus4_r;
    logic [31:0] instr_pcplus4_s;
    logic        instr_valid_r;
    logic        instr_valid_s;
    logic [31:0] target_s;

    // Sequential successor address; wraps at the top of the address space.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_s;
    logic        misalign_exc_r;
    logic [31:0] misalign_epc_r;

    // Resolve the redirect target; a misaligned target goes to the exception vector.
    always_comb begin
        misalign_s = 1'b0;
        target_s   = redirect_pc;
        if (redirect_pc[1:0] != 2'b00) begin
            misalign_s = 1'b1;
            target_s   = EXC_VECTOR;
        end else begin
            misalign_s = 1'b0;
            target_s   = redirect_pc;
        end
    end

    // Pulse the exception for one cycle and keep the offending address.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_exc_r <= 1'b0;
            misalign_epc_r <= 32'h0000_0000;
        end else if (redirect_valid && misalign_s) begin
            misalign_exc_r <= 1'b1;
            misalign_epc_r <= redirect_pc;
        end else begin
            misalign_exc_r <= 1'b0;
        end
    end

    assign misalign_exc = misalign_exc_r;
    assign misalign_epc = misalign_epc_r;
`else
    logic unused_cfg_s;

    assign target_s     = {redirect_pc[31:2], 2'b00};
    assign misalign_exc = 1'b0;
    assign misalign_epc = 32'h0000_0000;
    assign unused_cfg_s = ^{redirect_pc[1:0], EXC_VECTOR};
`endif

    // State register, PC and the decode-facing instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_FETCH;
            pc_r            <= RESET_PC;
            pending_pc_r    <= 32'h0000_0000;
            instr_r         <= 32'h0000_0000;
            instr_pc_r      <= 32'h0000_0000;
            instr_pcplus4_r <= 32'h0000_0000;
            instr_valid_r   <= 1'b0;
        end else begin
            state_r         <= state_s;
            pc_r            <= pc_s;
            pending_pc_r    <= pending_pc_s;
            instr_r         <= instr_s;
            instr_pc_r      <= instr_pc_s;
            instr_pcplus4_r <= instr_pcplus4_s;
            instr_valid_r   <= instr_valid_s;
        end
    end

    // Next-state and datapath updates for fetch, hand-off and dropped requests.
    always_comb begin
        state_s         = state_r;
        pc_s            = pc_r;
        pending_pc_s    = pending_pc_r;
        instr_s         = instr_r;
        instr_pc_s      = instr_pc_r;
        instr_pcplus4_s = instr_pcplus4_r;
        instr_valid_s   = instr_valid_r;
        case (state_r)
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        // Data belongs to the wrong path; refetch at the target.
                        pc_s = target_s;
                    end else begin
                        instr_s         = imem_rdata;
                        instr_pc_s      = pc_r;
                        instr_pcplus4_s = next_word(pc_r);
                        instr_valid_s   = 1'b1;
                        pc_s            = next_word(pc_r);
                        state_s         = S_OUT;
                    end
                end else if (redirect_valid) begin
                    // Memory must still answer the old address; remember the target.
                    pending_pc_s = target_s;
                    state_s      = S_DROP;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    instr_valid_s = 1'b0;
                    pc_s          = target_s;
                    state_s       = S_FETCH;
                end else if (instr_ready) begin
                    instr_valid_s = 1'b0;
                    state_s       = S_FETCH;
                end else begin
                    state_s = S_OUT;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    pc_s    = redirect_valid ? target_s : pending_pc_r;
                    state_s = S_FETCH;
                end else if (redirect_valid) begin
                    pending_pc_s = target_s;
                    state_s      = S_DROP;
                end else begin
                    state_s = S_DROP;
                end
            end
            default: begin
                state_s = S_FETCH;
            end
        endcase
    end

    // Memory request is high whenever a fetch is in flight and not in reset.
    always_comb begin
        imem_req = 1'b0;
        if (rst) begin
            imem_req = 1'b0;
        end else if ((state_r == S_FETCH) || (state_r == S_DROP)) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    assign imem_addr     = rst ? RESET_PC : pc_r;
    assign instr_valid   = instr_valid_r;
    assign instr         = instr_r;
    assign instr_pc      = instr_pc_r;
    assign instr_pcplus4 = instr_pcplus4_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. The bench drives randomized memory latency,
// decode backpressure, redirects and resets. It checks every output on every
// cycle against a transaction-level reference model.
// RESET_PC is set near the top of memory so that the first fetches wrap to zero.
module tb_fetch_sequencer;

    localparam logic [31:0] TB_RESET_PC   = 32'hFFFF_FFF8;
    localparam logic [31:0] TB_EXC_VECTOR = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_exc;
    logic [31:0] misalign_epc;

    fetch_sequencer #(
        .RESET_PC  (TB_RESET_PC),
        .EXC_VECTOR(TB_EXC_VECTOR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .misalign_exc  (misalign_exc),
        .misalign_epc  (misalign_epc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the fetch unit is doing, in transaction terms.
    logic        m_holding;      // an instruction is waiting for decode
    logic        m_stale;        // the outstanding fetch is on a dead path
    logic [31:0] m_fetch_pc;     // address being / to be fetched
    logic [31:0] m_stale_target; // where to go once the dead fetch returns
    logic [31:0] m_instr;
    logic [31:0] m_instr_pc;
    logic [31:0] m_pcplus4;
    logic        m_exc;
    logic [31:0] m_epc;

    // Memory responder state.
    logic        mem_busy;
    int          mem_cnt;
    int          lat_lo;
    int          lat_hi;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at time %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] redirect_dest(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        if ((t % 32'd4) != 32'd0) return TB_EXC_VECTOR;
        return t;
`else
        return t - (t % 32'd4);
`endif
    endfunction

    task automatic model_reset();
        m_holding      = 1'b0;
        m_stale        = 1'b0;
        m_fetch_pc     = TB_RESET_PC;
        m_stale_target = 32'd0;
        m_instr        = 32'd0;
        m_instr_pc     = 32'd0;
        m_pcplus4      = 32'd0;
        m_exc          = 1'b0;
        m_epc          = 32'd0;
        mem_busy       = 1'b0;
        mem_cnt        = 0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input logic do_rst, input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        ack;
        logic        exp_req;
        logic [31:0] dest;
        @(negedge clk);
        exp_req = !do_rst && !m_holding;
        ack     = 1'b0;
        if (do_rst) begin
            mem_busy = 1'b0;
        end else if (exp_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = int'($urandom_range(lat_hi, lat_lo));
            end
            if (mem_cnt == 0) begin
                ack      = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        rst            = do_rst;
        instr_ready    = rdy;
        redirect_valid = redir && !do_rst;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = ack ? mem_word(imem_addr) : $urandom();
        #1;
        check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check_eq("imem_addr", imem_addr, do_rst ? TB_RESET_PC : m_fetch_pc);
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
        check_eq("instr", instr, m_instr);
        check_eq("instr_pc", instr_pc, m_instr_pc);
        check_eq("instr_pcplus4", instr_pcplus4, m_pcplus4);
        check_eq("misalign_exc", {31'd0, misalign_exc}, {31'd0, m_exc});
        check_eq("misalign_epc", misalign_epc, m_epc);
        if (do_rst) begin
            model_reset();
        end else begin
            dest  = redirect_dest(rpc);
            m_exc = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redir && ((rpc % 32'd4) != 32'd0)) begin
                m_exc = 1'b1;
                m_epc = rpc;
            end
`endif
            if (m_holding) begin
                if (redir) begin
                    m_holding  = 1'b0;
                    m_fetch_pc = dest;
                end else if (rdy) begin
                    m_holding = 1'b0;
                end
            end else if (ack) begin
                if (m_stale) begin
                    m_fetch_pc = redir ? dest : m_stale_target;
                    m_stale    = 1'b0;
                end else if (redir) begin
                    m_fetch_pc = dest;
                end else begin
                    m_holding  = 1'b1;
                    m_instr    = mem_word(m_fetch_pc);
                    m_instr_pc = m_fetch_pc;
                    m_pcplus4  = m_fetch_pc + 32'd4;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end else if (redir) begin
                m_stale        = 1'b1;
                m_stale_target = dest;
            end
        end
    endtask

    // Run with decode stalled until an instruction is on offer (bounded).
    task automatic wait_valid();
        int i;
        i = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            i++;
        end while (!instr_valid && i < 30);
        check_eq("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] rpc;
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        lat_lo         = 1;
        lat_hi         = 1;
        model_reset();
        repeat (2) @(posedge clk);
        step(1'b1, 1'b1, 1'b0, 32'd0);

        // Straight-line fetch through the address wrap, decode always ready.
        repeat (14) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Decode stalls five cycles with an instruction on offer.
        wait_valid();
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Redirect while an instruction waits for a stalled decode.
        wait_valid();
        step(1'b0, 1'b0, 1'b1, 32'h0000_1000);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Two redirects during a four-cycle fetch of 0x40.
        lat_lo = 3;
        lat_hi = 3;
        wait_valid();
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        repeat (10) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Misaligned redirect target.
        lat_lo = 1;
        lat_hi = 1;
        wait_valid();
        step(1'b0, 1'b0, 1'b1, 32'h0000_1002);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);

        // Randomized traffic: variable latency, backpressure, redirects, resets.
        lat_lo = 0;
        lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom();
            if ($urandom_range(1, 0) == 1) rpc[1:0] = 2'b00;
            step(($urandom_range(99, 0) < 1),
                 ($urandom_range(99, 0) < 70),
                 ($urandom_range(99, 0) < 10),
                 rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
